regfile_wb_buffer: RTL and testbench

REGFILE_WB_BUFFER -- requirements
Module: regfile_wb_buffer

---
 rtl/regfile_wb_buffer.sv | 135 +++++++++++++
 tb/tb_regfile_wb_buffer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_buffer.sv
// Writeback buffer between producers and the register file: a circular FIFO that
// drains up to NR_COMMIT_PORTS entries per cycle and forwards pending writes.
module regfile_wb_buffer #(
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned NR_WB_PORTS     = 2,
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned NR_READ_PORTS   = 2,
    parameter int unsigned DEPTH           = 8,
    parameter bit          ZERO_REG_ZERO   = 1'b1
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  logic                                         flush_i,
    input  logic                                         wr_stall_i,
    input  logic [NR_WB_PORTS-1:0]                       wb_valid_i,
    output logic [NR_WB_PORTS-1:0]                       wb_ready_o,
    input  logic [NR_WB_PORTS-1:0][4:0]                  wb_addr_i,
    input  logic [NR_WB_PORTS-1:0][DATA_WIDTH-1:0]       wb_data_i,
    output logic [NR_COMMIT_PORTS-1:0][4:0]              waddr_o,
    output logic [NR_COMMIT_PORTS-1:0][DATA_WIDTH-1:0]   wdata_o,
    output logic [NR_COMMIT_PORTS-1:0]                   we_o,
    input  logic [NR_READ_PORTS-1:0][4:0]                raddr_i,
    output logic [NR_READ_PORTS-1:0]                     fwd_hit_o,
    output logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0]     fwd_data_o,
    output logic [$clog2(DEPTH):0]                       count_o,
    output logic                                         full_o,
    output logic                                         empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [CNT_W-1:0]      r_count;
    logic [4:0]            r_addr [DEPTH];
    logic [DATA_WIDTH-1:0] r_data [DEPTH];

    logic [NR_WB_PORTS-1:0]            w_accept;
    logic [NR_WB_PORTS-1:0][PTR_W-1:0] w_push_idx;
    logic [CNT_W-1:0]                  w_push_cnt;
    logic [CNT_W-1:0]                  w_pop_cnt;

    // Ready depends only on registered occupancy, never on this cycle's valids or drains.
    always_comb begin
        for (int i = 0; i < int'(NR_WB_PORTS); i++) begin
            wb_ready_o[i] = !rst_i && (int'(r_count) < int'(DEPTH) - i);
        end
    end

    // Accepted ports are packed into consecutive slots starting at the tail.
    always_comb begin
        // NOTE: every combinational output gets a default before any conditional update,
        // so no path leaves a value unassigned and no latch is inferred.
        w_push_cnt = '0;
        for (int i = 0; i < int'(NR_WB_PORTS); i++) begin
            w_accept[i]   = wb_valid_i[i] && wb_ready_o[i];
            w_push_idx[i] = r_tail + PTR_W'(w_push_cnt);
            if (w_accept[i]) begin
                w_push_cnt = w_push_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        logic [PTR_W-1:0] idx;
        logic             present;
        w_pop_cnt = '0;
        for (int k = 0; k < int'(NR_COMMIT_PORTS); k++) begin
            idx        = r_head + PTR_W'(k);
            present    = k < int'(r_count);
            waddr_o[k] = r_addr[idx];
            wdata_o[k] = r_data[idx];
            we_o[k]    = present && !wr_stall_i && !flush_i && !rst_i &&
                         !(ZERO_REG_ZERO && r_addr[idx] == 5'd0);
            if (present) begin
                w_pop_cnt = w_pop_cnt + CNT_W'(1);
            end
        end
        if (wr_stall_i) begin
            w_pop_cnt = '0;
        end
    end

    // Scan oldest to youngest so the last match (youngest) wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        for (int r = 0; r < int'(NR_READ_PORTS); r++) begin
            fwd_hit_o[r]  = 1'b0;
            fwd_data_o[r] = '0;
            for (int j = 0; j < int'(DEPTH); j++) begin
                idx = r_head + PTR_W'(j);
                if (j < int'(r_count) && r_addr[idx] == raddr_i[r]) begin
                    fwd_hit_o[r]  = 1'b1;
                    fwd_data_o[r] = r_data[idx];
                end
            end
            if (rst_i || (ZERO_REG_ZERO && raddr_i[r] == 5'd0)) begin
                fwd_hit_o[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PTR_W'(w_pop_cnt);
            r_tail  <= r_tail + PTR_W'(w_push_cnt);
            r_count <= r_count + w_push_cnt - w_pop_cnt;
        end
    end

    // NOTE: entry storage is deliberately not reset; validity is defined purely by
    // head/count, so stale contents are never observed.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < int'(NR_WB_PORTS); i++) begin
            if (w_accept[i] && !flush_i) begin
                r_addr[w_push_idx[i]] <= wb_addr_i[i];
                r_data[w_push_idx[i]] <= wb_data_i[i];
            end
        end
    end

    assign count_o = r_count;
    assign full_o  = (r_count == CNT_W'(DEPTH));
    assign empty_o = (r_count == '0);

endmodule

// File: tb/tb_regfile_wb_buffer.sv
// Self-checking bench: directed scenarios with literal expectations plus a randomized
// run compared every cycle against a queue-based model of the buffer.
module tb_regfile_wb_buffer;

    localparam int DW    = 64;
    localparam int NWB   = 2;
    localparam int NCP   = 2;
    localparam int NRD   = 2;
    localparam int DEPTH = 8;

    logic                     clk_i = 1'b0;
    logic                     rst_i;
    logic                     flush_i;
    logic                     wr_stall_i;
    logic [NWB-1:0]           wb_valid_i;
    logic [NWB-1:0]           wb_ready_o;
    logic [NWB-1:0][4:0]      wb_addr_i;
    logic [NWB-1:0][DW-1:0]   wb_data_i;
    logic [NCP-1:0][4:0]      waddr_o;
    logic [NCP-1:0][DW-1:0]   wdata_o;
    logic [NCP-1:0]           we_o;
    logic [NRD-1:0][4:0]      raddr_i;
    logic [NRD-1:0]           fwd_hit_o;
    logic [NRD-1:0][DW-1:0]   fwd_data_o;
    logic [$clog2(DEPTH):0]   count_o;
    logic                     full_o;
    logic                     empty_o;

    regfile_wb_buffer #(
        .DATA_WIDTH(DW), .NR_WB_PORTS(NWB), .NR_COMMIT_PORTS(NCP),
        .NR_READ_PORTS(NRD), .DEPTH(DEPTH), .ZERO_REG_ZERO(1'b1)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .wr_stall_i(wr_stall_i),
        .wb_valid_i(wb_valid_i), .wb_ready_o(wb_ready_o), .wb_addr_i(wb_addr_i),
        .wb_data_i(wb_data_i), .waddr_o(waddr_o), .wdata_o(wdata_o), .we_o(we_o),
        .raddr_i(raddr_i), .fwd_hit_o(fwd_hit_o), .fwd_data_o(fwd_data_o),
        .count_o(count_o), .full_o(full_o), .empty_o(empty_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [4:0]    addr;
        logic [DW-1:0] data;
    } ent_t;

    ent_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected outputs follow directly from the queue contents and current inputs.
    task automatic compare_model();
        int n;
        logic exp_we;
        logic hit;
        logic [DW-1:0] d;
        n = q.size();
        check("count", 64'(count_o), 64'(n));
        check("empty", 64'(empty_o), 64'(n == 0));
        check("full", 64'(full_o), 64'(n == DEPTH));
        for (int i = 0; i < NWB; i++)
            check($sformatf("ready[%0d]", i), 64'(wb_ready_o[i]), 64'((DEPTH - n) > i));
        for (int k = 0; k < NCP; k++) begin
            exp_we = 1'b0;
            if (k < n) begin
                check($sformatf("waddr[%0d]", k), 64'(waddr_o[k]), 64'(q[k].addr));
                check($sformatf("wdata[%0d]", k), 64'(wdata_o[k]), 64'(q[k].data));
                exp_we = !wr_stall_i && !flush_i && (q[k].addr != 5'd0);
            end
            check($sformatf("we[%0d]", k), 64'(we_o[k]), 64'(exp_we));
        end
        for (int r = 0; r < NRD; r++) begin
            hit = 1'b0;
            d   = '0;
            if (raddr_i[r] != 5'd0) begin
                foreach (q[j]) begin
                    if (q[j].addr == raddr_i[r]) begin
                        hit = 1'b1;
                        d   = q[j].data;
                    end
                end
            end
            check($sformatf("fwd_hit[%0d]", r), 64'(fwd_hit_o[r]), 64'(hit));
            if (hit) check($sformatf("fwd_data[%0d]", r), 64'(fwd_data_o[r]), 64'(d));
        end
    endtask

    task automatic update_model();
        int n;
        int npop;
        n = q.size();
        if (flush_i) begin
            q.delete();
            return;
        end
        npop = wr_stall_i ? 0 : ((n < NCP) ? n : NCP);
        for (int i = 0; i < NWB; i++)
            if (wb_valid_i[i] && (DEPTH - n) > i) q.push_back('{wb_addr_i[i], wb_data_i[i]});
        repeat (npop) void'(q.pop_front());
    endtask

    task automatic step();
        compare_model();
        update_model();
        @(negedge clk_i);
    endtask

    task automatic set_wb(input logic [1:0] v, input logic [4:0] a0, input logic [DW-1:0] d0,
                          input logic [4:0] a1, input logic [DW-1:0] d1);
        wb_valid_i   = v;
        wb_addr_i[0] = a0;
        wb_data_i[0] = d0;
        wb_addr_i[1] = a1;
        wb_data_i[1] = d1;
    endtask

    initial begin
        rst_i      = 1'b1;
        flush_i    = 1'b0;
        wr_stall_i = 1'b0;
        raddr_i    = '0;
        set_wb(2'b00, 5'd0, '0, 5'd0, '0);
        repeat (2) @(negedge clk_i);
        #1;
        check("rst ready", 64'(wb_ready_o), 64'(0));
        check("rst count", 64'(count_o), 64'(0));
        check("rst empty", 64'(empty_o), 64'(1));
        check("rst full", 64'(full_o), 64'(0));
        check("rst we", 64'(we_o), 64'(0));
        rst_i = 1'b0;
        #1;
        check("post-rst ready", 64'(wb_ready_o), 64'(2'b11));
        q.delete();
        @(negedge clk_i);

        // Single write to x5
        set_wb(2'b01, 5'd5, 64'hDEAD, 5'd0, '0);
        #1 step();
        set_wb(2'b00, 5'd0, '0, 5'd0, '0);
        #1;
        check("single we0", 64'(we_o[0]), 64'(1));
        check("single waddr0", 64'(waddr_o[0]), 64'(5));
        check("single wdata0", 64'(wdata_o[0]), 64'hDEAD);
        check("single we1", 64'(we_o[1]), 64'(0));
        step();
        #1 check("single drained", 64'(count_o), 64'(0));
        step();

        // Fill under stall, then drain two per cycle across the pointer wrap
        wr_stall_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            set_wb(2'b11, 5'(8 + 2 * c), 64'(256 + 2 * c), 5'(9 + 2 * c), 64'(257 + 2 * c));
            #1 step();
        end
        set_wb(2'b00, 5'd0, '0, 5'd0, '0);
        #1;
        check("fill count", 64'(count_o), 64'(8));
        check("fill full", 64'(full_o), 64'(1));
        check("fill ready", 64'(wb_ready_o), 64'(0));
        step();
        wr_stall_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("drain we", 64'(we_o), 64'(2'b11));
            check("drain wdata0", 64'(wdata_o[0]), 64'(256 + 2 * c));
            check("drain wdata1", 64'(wdata_o[1]), 64'(257 + 2 * c));
            step();
        end
        #1 check("drain empty", 64'(empty_o), 64'(1));
        step();

        // Same destination on both ports
        set_wb(2'b11, 5'd7, 64'd1, 5'd7, 64'd2);
        #1 step();
        set_wb(2'b00, 5'd0, '0, 5'd0, '0);
        raddr_i[0] = 5'd7;
        #1;
        check("same waddr0", 64'(waddr_o[0]), 64'(7));
        check("same waddr1", 64'(waddr_o[1]), 64'(7));
        check("same wdata1", 64'(wdata_o[1]), 64'(2));
        check("same fwd hit", 64'(fwd_hit_o[0]), 64'(1));
        check("same fwd data", 64'(fwd_data_o[0]), 64'(2));
        step();

        // Write to x0
        set_wb(2'b01, 5'd0, 64'h55, 5'd0, '0);
        raddr_i[0] = 5'd0;
        #1 step();
        set_wb(2'b00, 5'd0, '0, 5'd0, '0);
        #1;
        check("x0 we0", 64'(we_o[0]), 64'(0));
        check("x0 count", 64'(count_o), 64'(1));
        check("x0 fwd hit", 64'(fwd_hit_o[0]), 64'(0));
        step();
        #1 check("x0 popped", 64'(count_o), 64'(0));
        step();

        // Flush with five entries and two concurrent valids
        wr_stall_i = 1'b1;
        set_wb(2'b11, 5'd3, 64'h31, 5'd4, 64'h41);
        #1 step();
        set_wb(2'b11, 5'd5, 64'h51, 5'd6, 64'h61);
        #1 step();
        set_wb(2'b01, 5'd10, 64'hA1, 5'd0, '0);
        #1 step();
        wr_stall_i = 1'b0;
        flush_i    = 1'b1;
        set_wb(2'b11, 5'd11, 64'hB1, 5'd12, 64'hC1);
        #1;
        check("flush count before", 64'(count_o), 64'(5));
        check("flush we", 64'(we_o), 64'(0));
        step();
        flush_i = 1'b0;
        set_wb(2'b00, 5'd0, '0, 5'd0, '0);
        #1;
        check("flush count", 64'(count_o), 64'(0));
        check("flush empty", 64'(empty_o), 64'(1));
        check("flush we after", 64'(we_o), 64'(0));
        step();
        #1 step();

        // Asynchronous reset with three entries buffered
        wr_stall_i = 1'b1;
        set_wb(2'b11, 5'd12, 64'h12, 5'd13, 64'h13);
        #1 step();
        set_wb(2'b01, 5'd14, 64'h14, 5'd0, '0);
        #1 step();
        set_wb(2'b00, 5'd0, '0, 5'd0, '0);
        wr_stall_i = 1'b0;
        raddr_i[0] = 5'd12;
        #1;
        check("pre-rst count", 64'(count_o), 64'(3));
        check("pre-rst hit", 64'(fwd_hit_o[0]), 64'(1));
        rst_i = 1'b1;
        #1;
        check("async rst count", 64'(count_o), 64'(0));
        check("async rst empty", 64'(empty_o), 64'(1));
        check("async rst full", 64'(full_o), 64'(0));
        check("async rst ready", 64'(wb_ready_o), 64'(0));
        check("async rst we", 64'(we_o), 64'(0));
        check("async rst hit", 64'(fwd_hit_o[0]), 64'(0));
        @(negedge clk_i);
        rst_i = 1'b0;
        q.delete();
        raddr_i = '0;
        #1;
        check("rel ready", 64'(wb_ready_o), 64'(2'b11));
        check("rel count", 64'(count_o), 64'(0));
        step();

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            wr_stall_i = ($urandom_range(0, 2) == 0);
            flush_i    = ($urandom_range(0, 31) == 0);
            set_wb(2'($urandom_range(0, 3)),
                   5'($urandom_range(0, 7)), {$urandom, $urandom},
                   5'($urandom_range(0, 7)), {$urandom, $urandom});
            raddr_i[0] = 5'($urandom_range(0, 7));
            raddr_i[1] = 5'($urandom_range(0, 7));
            #1 step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
